// File: rtl/logic_pkg.sv
// Shared definitions for the logical-unit front end: opcodes, FSM states
// and requester IDs.
package logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/logic_arbiter_logical.sv
// The shared 4-bit logical unit: operates on the two nibbles of the
// operand word, or inverts the whole word for NOT.
module Logical
  import logic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] result_o
);

  logic [3:0] x;
  logic [3:0] y;

  assign x = data_i[3:0];
  assign y = data_i[7:4];

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = {{(W-4){1'b0}}, x & y};
      OP_OR:   result_o = {{(W-4){1'b0}}, x | y};
      OP_XOR:  result_o = {{(W-4){1'b0}}, x ^ y};
      OP_NOT:  result_o = ~data_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the requester that did not win last
// time is granted; last_id resets to B so that A wins the first tie.
module rr_arb2
  import logic_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_id_q;
  logic last_id_d;

  always_comb begin
    gnt_a_o   = en_i && req_a_i && (!req_b_i || (last_id_q == ID_B));
    gnt_b_o   = en_i && req_b_i && (!req_a_i || (last_id_q == ID_A));
    last_id_d = last_id_q;
    if (gnt_a_o)      last_id_d = ID_A;
    else if (gnt_b_o) last_id_d = ID_B;
  end

  always_ff @(posedge clk) begin
    if (reset) last_id_q <= ID_B;
    else       last_id_q <= last_id_d;
  end

endmodule

// File: rtl/logic_arbiter.sv
// Two-requester front end for the logical unit: arbitrates, captures the
// winning request, executes it and returns a tagged valid/ready response.
module logic_arbiter
  import logic_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [1:0]       a_op,
  input  logic [W-1:0]     a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [1:0]       b_op,
  input  logic [W-1:0]     b_data,
  output logic             b_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_t           state_q;
  logic [1:0]       op_q;
  logic [W-1:0]     data_q;
  logic             id_q;
  logic             rsp_valid_q;
  logic [W-1:0]     rsp_result_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] ops_done_q;
  logic [CNT_W-1:0] ops_done_d;
  logic [W-1:0]     unit_result;
  logic             gnt_a;
  logic             gnt_b;
  logic             arb_en;

  // No grant during reset: an accepted request would otherwise be lost.
  assign arb_en = (state_q == ST_IDLE) && !reset;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (arb_en),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  Logical #(.W(W)) u_logical (
    .op_i     (op_q),
    .data_i   (data_q),
    .result_o (unit_result)
  );

  assign ops_done_d = ops_done_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      data_q       <= '0;
      id_q         <= ID_A;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= ID_A;
      ops_done_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_a || gnt_b) begin
            op_q    <= gnt_b ? b_op : a_op;
            data_q  <= gnt_b ? b_data : a_data;
            id_q    <= gnt_b ? ID_B : ID_A;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= unit_result;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ops_done_q  <= ops_done_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_ready    = gnt_a;
  assign b_ready    = gnt_b;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != ST_IDLE);
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter with a scoreboard of expected responses
// filled at request acceptance and drained at each response handshake.
module tb_logic_arbiter;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             a_valid = 1'b0;
  logic [1:0]       a_op = '0;
  logic [W-1:0]     a_data = '0;
  logic             a_ready;
  logic             b_valid = 1'b0;
  logic [1:0]       b_op = '0;
  logic [W-1:0]     b_data = '0;
  logic             b_ready;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [W-1:0]     rsp_result;
  logic             rsp_id;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_ops = '0;

  logic_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_op       (a_op),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_op       (b_op),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d);
    case (op)
      2'b00:   return {4'h0, d[3:0] & d[7:4]};
      2'b01:   return {4'h0, d[3:0] | d[7:4]};
      2'b10:   return {4'h0, d[3:0] ^ d[7:4]};
      default: return ~d;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One uncontended request with rsp_ready held high; starts and ends in IDLE.
  task automatic single(input logic id, input logic [1:0] op, input logic [W-1:0] d);
    logic [W-1:0] e;
    e = model(op, d);
    tick();
    if (id) begin b_valid = 1'b1; b_op = op; b_data = d; end
    else    begin a_valid = 1'b1; a_op = op; a_data = d; end
    @(negedge clk);
    chk("grant_ready", id ? b_ready : a_ready, 1);
    chk("other_ready", id ? a_ready : b_ready, 0);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_no_rsp", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, e);
    chk("rsp_id", rsp_id, id);
    tick();
    exp_ops++;
    @(negedge clk);
    chk("ops_done", ops_done, exp_ops);
    chk("idle_busy", busy, 0);
  endtask

  // Scoreboard: push at acceptance, compare at response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("ready_exclusive", a_ready & b_ready, 0);
      if (a_valid && a_ready) sb.push_back({1'b0, model(a_op, a_data)});
      if (b_valid && b_ready) sb.push_back({1'b1, model(b_op, b_data)});
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed response %0h with no pending request", rsp_result);
        end else begin
          e = sb.pop_front();
          chk("sb_result", rsp_result, e.res);
          chk("sb_id", rsp_id, e.id);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);

    // Single requesters
    single(1'b0, 2'b00, 8'hC6);
    chk("a_and_result", rsp_result, 8'h04);
    single(1'b1, 2'b11, 8'h5A);
    chk("b_not_result", rsp_result, 8'hA5);
    single(1'b1, 2'b10, 8'hF3);
    chk("b_xor_result", rsp_result, 8'h0C);

    // Continuous tie from reset: alternate A, B, A, B every 3 cycles
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ops = '0;
    a_valid = 1'b1; a_op = 2'b10; a_data = 8'h3C;
    b_valid = 1'b1; b_op = 2'b11; b_data = 8'h0F;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tie_a_ready", a_ready, (k % 2) == 0);
      chk("tie_b_ready", b_ready, (k % 2) == 1);
      tick();
      @(negedge clk);
      chk("tie_exec_ready", {a_ready, b_ready}, 0);
      tick();
      @(negedge clk);
      chk("tie_rsp_valid", rsp_valid, 1);
      chk("tie_rsp_id", rsp_id, (k % 2) == 1);
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    exp_ops = exp_ops + 4'd4;
    @(negedge clk);
    chk("tie_ops_done", ops_done, exp_ops);

    // Back-pressure: RESP held 5 cycles, B waits meanwhile
    tick();
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_op = 2'b01; a_data = 8'h21;
    @(negedge clk);
    chk("bp_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b1; b_op = 2'b11; b_data = 8'h00;
    @(negedge clk);
    chk("bp_exec_b_ready", b_ready, 0);
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 8'h03);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_readies", {a_ready, b_ready}, 0);
      chk("bp_ops_hold", ops_done, exp_ops);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ops_before_hs", ops_done, exp_ops);
    tick();
    exp_ops++;
    @(negedge clk);
    chk("bp_b_granted", b_ready, 1);
    chk("bp_ops_after_hs", ops_done, exp_ops);
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_b_result", rsp_result, 8'hFF);
    chk("bp_b_id", rsp_id, 1);
    tick();
    exp_ops++;
    @(negedge clk);
    chk("bp_ops_final", ops_done, exp_ops);

    // Reset during EXEC discards the request
    tick();
    a_valid = 1'b1; a_op = 2'b10; a_data = 8'hFF;
    @(negedge clk);
    chk("rx_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rx_in_exec", busy, 1);
    tick();
    reset = 1'b0;
    sb.delete();
    exp_ops = '0;
    @(negedge clk);
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_busy", busy, 0);
    chk("rx_ops_done", ops_done, 0);
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("rx_no_rsp", rsp_valid, 0);
    end
    tick();
    a_valid = 1'b1; a_op = 2'b00; a_data = 8'hFF;
    b_valid = 1'b1; b_op = 2'b01; b_data = 8'h12;
    @(negedge clk);
    chk("rx_tie_a", a_ready, 1);
    chk("rx_tie_b", b_ready, 0);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rx_tie_id", rsp_id, 0);
    chk("rx_tie_result", rsp_result, 8'h0F);
    tick();
    exp_ops++;
    @(negedge clk);
    chk("rx_tie_ops", ops_done, exp_ops);

    // Counter wrap (CNT_W = 4): run up to 15, then one more
    for (int unsigned n = 0; n < 20 && exp_ops != 4'hF; n++)
      single(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
    chk("pre_wrap", ops_done, 4'hF);
    single(1'b0, 2'b11, 8'h0F);
    chk("wrap_ops_done", ops_done, 0);
    chk("wrap_result", rsp_result, 8'hF0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
